// File: rtl/hazard_unit.sv
// hazard_unit: ID-stage data-hazard detection with a shadow EXE/MEM/WB destination pipeline.
// Define HAZARD_FORWARD_EN to enable EXE operand forwarding; otherwise every RAW hazard stalls.
module hazard_unit #(
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [4:0]             id_rs_addr,
  input  logic [4:0]             id_rt_addr,
  input  logic                   id_rs_used,
  input  logic                   id_rt_used,
  input  logic                   id_wb_wen,
  input  logic [4:0]             id_wb_addr,
  input  logic                   id_mem_ren,
  input  logic                   exe_en,
  input  logic                   exe_rst,
  input  logic                   mem_en,
  input  logic                   mem_rst,
  input  logic                   wb_en,
  input  logic                   wb_rst,
  output logic                   reg_stall,
  output logic [1:0]             exe_fwd_a,
  output logic [1:0]             exe_fwd_b,
  output logic [STALL_CNT_W-1:0] stall_count
);
  logic [4:0] exe_dst_q, exe_dst_d, mem_dst_q, mem_dst_d, wb_dst_q, wb_dst_d;
  logic exe_wen_q, exe_wen_d, exe_load_q, exe_load_d;
  logic mem_wen_q, mem_wen_d, mem_load_q, mem_load_d;
  logic wb_wen_q, wb_wen_d;
  logic [STALL_CNT_W-1:0] cnt_q, cnt_d;
  logic exe_prod, mem_prod, exe_rs_m, exe_rt_m, mem_rs_m, mem_rt_m, stall, exe_clr;
  logic unused;
  always_comb begin
    exe_prod = exe_wen_q && exe_dst_q != 5'd0;
    mem_prod = mem_wen_q && mem_dst_q != 5'd0;
    exe_rs_m = exe_prod && id_rs_used && id_rs_addr == exe_dst_q;
    exe_rt_m = exe_prod && id_rt_used && id_rt_addr == exe_dst_q;
    mem_rs_m = mem_prod && id_rs_used && id_rs_addr == mem_dst_q;
    mem_rt_m = mem_prod && id_rt_used && id_rt_addr == mem_dst_q;
  end
  assign reg_stall = rst_n && stall;
  // A stalled ID instruction must not enter EXE: the slot turns into a bubble.
  always_comb begin
    exe_clr    = exe_rst || (exe_en && reg_stall);
    exe_dst_d  = exe_clr ? 5'd0 : exe_en ? id_wb_addr : exe_dst_q;
    exe_wen_d  = exe_clr ? 1'b0 : exe_en ? id_wb_wen  : exe_wen_q;
    exe_load_d = exe_clr ? 1'b0 : exe_en ? id_mem_ren : exe_load_q;
    mem_dst_d  = mem_rst ? 5'd0 : mem_en ? exe_dst_q  : mem_dst_q;
    mem_wen_d  = mem_rst ? 1'b0 : mem_en ? exe_wen_q  : mem_wen_q;
    mem_load_d = mem_rst ? 1'b0 : mem_en ? exe_load_q : mem_load_q;
    wb_dst_d   = wb_rst  ? 5'd0 : wb_en  ? mem_dst_q  : wb_dst_q;
    wb_wen_d   = wb_rst  ? 1'b0 : wb_en  ? mem_wen_q  : wb_wen_q;
    cnt_d      = (reg_stall && (exe_en || mem_en || wb_en) && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exe_dst_q  <= 5'd0;
      exe_wen_q  <= 1'b0;
      exe_load_q <= 1'b0;
      mem_dst_q  <= 5'd0;
      mem_wen_q  <= 1'b0;
      mem_load_q <= 1'b0;
      wb_dst_q   <= 5'd0;
      wb_wen_q   <= 1'b0;
      cnt_q      <= '0;
    end else begin
      exe_dst_q  <= exe_dst_d;
      exe_wen_q  <= exe_wen_d;
      exe_load_q <= exe_load_d;
      mem_dst_q  <= mem_dst_d;
      mem_wen_q  <= mem_wen_d;
      mem_load_q <= mem_load_d;
      wb_dst_q   <= wb_dst_d;
      wb_wen_q   <= wb_wen_d;
      cnt_q      <= cnt_d;
    end
  end
  assign stall_count = cnt_q;
`ifdef HAZARD_FORWARD_EN
  logic [1:0] fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
  // Only a load still in EXE cannot be forwarded in time.
  assign stall = exe_load_q && (exe_rs_m || exe_rt_m);
  always_comb begin
    fwd_a_d = (exe_rs_m && !exe_load_q) ? 2'd1 : mem_rs_m ? 2'd2 : 2'd0;
    fwd_b_d = (exe_rt_m && !exe_load_q) ? 2'd1 : mem_rt_m ? 2'd2 : 2'd0;
    fwd_a_d = exe_clr ? 2'd0 : exe_en ? fwd_a_d : fwd_a_q;
    fwd_b_d = exe_clr ? 2'd0 : exe_en ? fwd_b_d : fwd_b_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_a_q <= 2'd0;
      fwd_b_q <= 2'd0;
    end else begin
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
    end
  end
  assign exe_fwd_a = fwd_a_q;
  assign exe_fwd_b = fwd_b_q;
  assign unused = ^{mem_load_q, wb_dst_q, wb_wen_q};
`else
  assign stall     = exe_rs_m || exe_rt_m || mem_rs_m || mem_rt_m;
  assign exe_fwd_a = 2'd0;
  assign exe_fwd_b = 2'd0;
  assign unused    = ^{exe_load_q, mem_load_q, wb_dst_q, wb_wen_q};
`endif
endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: directed checks of hazard_unit; expectations follow HAZARD_FORWARD_EN.
module tb_hazard_unit;
`ifdef HAZARD_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n;
  logic [4:0] id_rs_addr, id_rt_addr, id_wb_addr;
  logic id_rs_used, id_rt_used, id_wb_wen, id_mem_ren;
  logic exe_en, exe_rst, mem_en, mem_rst, wb_en, wb_rst;
  logic reg_stall;
  logic [1:0] exe_fwd_a, exe_fwd_b;
  logic [3:0] stall_count;
  int passed = 0;
  int total = 0;
  int exp_cnt = 0;

  hazard_unit #(.STALL_CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
    .id_wb_wen(id_wb_wen), .id_wb_addr(id_wb_addr), .id_mem_ren(id_mem_ren),
    .exe_en(exe_en), .exe_rst(exe_rst), .mem_en(mem_en), .mem_rst(mem_rst),
    .wb_en(wb_en), .wb_rst(wb_rst),
    .reg_stall(reg_stall), .exe_fwd_a(exe_fwd_a), .exe_fwd_b(exe_fwd_b),
    .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic [4:0] rs, input logic [4:0] rt, input logic rsu,
                        input logic rtu, input logic wen, input logic [4:0] wa, input logic ren);
    id_rs_addr = rs; id_rt_addr = rt; id_rs_used = rsu; id_rt_used = rtu;
    id_wb_wen = wen; id_wb_addr = wa; id_mem_ren = ren;
  endtask

  task automatic flush();
    set_id(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    repeat (3) tick();
  endtask

  task automatic bump();
    exp_cnt = (exp_cnt == 15) ? 15 : exp_cnt + 1;
  endtask

  // Dependent R-type in ID: expect n stall cycles, then the given selects in EXE.
  task automatic dep(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] wa,
                     input int n, input logic [1:0] fa, input logic [1:0] fb, input string tag);
    set_id(rs, rt, 1'b1, 1'b1, 1'b1, wa, 1'b0);
    for (int i = 0; i < n; i++) begin
      #1 check({tag, " stall"}, reg_stall, 1);
      tick();
      bump();
    end
    #1 check({tag, " released"}, reg_stall, 0);
    tick();
    check({tag, " fwd_a"}, exe_fwd_a, fa);
    check({tag, " fwd_b"}, exe_fwd_b, fb);
    check({tag, " count"}, stall_count, exp_cnt);
  endtask

  initial begin
    rst_n = 1'b0;
    exe_en = 1'b1; mem_en = 1'b1; wb_en = 1'b1;
    exe_rst = 1'b0; mem_rst = 1'b0; wb_rst = 1'b0;
    set_id(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    #3;
    check("reset stall", reg_stall, 0);
    check("reset count", stall_count, 0);
    check("reset fwd_a", exe_fwd_a, 0);
    check("reset fwd_b", exe_fwd_b, 0);
    tick();
    rst_n = 1'b1;
    flush();

    // add $3,$1,$2 ; sub $4,$3,$1
    set_id(5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd3, 1'b0);
    #1 check("add3 stall", reg_stall, 0);
    tick();
    dep(5'd3, 5'd1, 5'd4, FWD ? 0 : 2, FWD ? 2'd1 : 2'd0, 2'd0, "add_sub");

    // lw $5,0($1) ; add $6,$5,$5
    flush();
    set_id(5'd1, 5'd5, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1);
    #1 check("lw5 stall", reg_stall, 0);
    tick();
    dep(5'd5, 5'd5, 5'd6, FWD ? 1 : 2, FWD ? 2'd2 : 2'd0, FWD ? 2'd2 : 2'd0, "load_use");

    // add $3 ; and $9,$1,$2 ; or $8,$3,$3
    flush();
    set_id(5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd3, 1'b0);
    tick();
    set_id(5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd9, 1'b0);
    #1 check("gap indep stall", reg_stall, 0);
    tick();
    dep(5'd3, 5'd3, 5'd8, FWD ? 0 : 1, FWD ? 2'd2 : 2'd0, FWD ? 2'd2 : 2'd0, "gap1");

    // add $0,$1,$2 ; add $7,$0,$0
    flush();
    set_id(5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0);
    tick();
    dep(5'd0, 5'd0, 5'd7, 0, 2'd0, 2'd0, "dst0_alu");

    // lw $0 ; dependent on $0
    flush();
    set_id(5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 5'd0, 1'b1);
    tick();
    dep(5'd0, 5'd1, 5'd7, 0, 2'd0, 2'd0, "dst0_lw");

    // exe_rst squashes the producer entering EXE
    flush();
    set_id(5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd3, 1'b0);
    exe_rst = 1'b1;
    tick();
    exe_rst = 1'b0;
    dep(5'd3, 5'd3, 5'd8, 0, 2'd0, 2'd0, "exe_rst");

    // Stage hold freezes slots and counter
    flush();
    set_id(5'd1, 5'd5, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1);
    tick();
    set_id(5'd5, 5'd5, 1'b1, 1'b1, 1'b1, 5'd6, 1'b0);
    #1 check("hold pre stall", reg_stall, 1);
    exe_en = 1'b0; mem_en = 1'b0; wb_en = 1'b0;
    repeat (3) tick();
    check("hold stall", reg_stall, 1);
    check("hold count", stall_count, exp_cnt);

    // Saturation: LW frozen in EXE keeps the stall asserted
    wb_en = 1'b1;
    repeat (20) begin
      tick();
      bump();
    end
    check("sat count", stall_count, 15);
    check("sat model", stall_count, exp_cnt);
    check("sat stall", reg_stall, 1);

    // Asynchronous reset mid-stream
    rst_n = 1'b0;
    #1;
    check("areset stall", reg_stall, 0);
    check("areset count", stall_count, 0);
    check("areset fwd_a", exe_fwd_a, 0);
    check("areset fwd_b", exe_fwd_b, 0);
    exe_en = 1'b1; mem_en = 1'b1;
    tick();
    rst_n = 1'b1;
    exp_cnt = 0;
    #1 check("post reset stall", reg_stall, 0);
    tick();
    check("post reset count", stall_count, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
